controle_medida_hcsr04: RTL and testbench

- Measurement controller sitting directly upstream of the cm-counting stage.
- Fires the HC-SR04 trigger and synchronizes the raw echo into the `pulso` fed to the counter.
- Supervises echo timeout, waits for the counter's completion, then latches the 3 BCD digits into a stable measurement register.
- One measurement per `medir` request; reports `pronto` or `timeout`.

---
 rtl/controle_medida_hcsr04_pkg.sv | 33 +++
 rtl/controle_medida_hcsr04_if.sv | 27 ++
 rtl/controle_medida_hcsr04_sincronizador_echo.sv | 49 ++++
 rtl/controle_medida_hcsr04.sv | 122 ++++++++++++
 tb/tb_controle_medida_hcsr04.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/controle_medida_hcsr04_pkg.sv
// Shared definitions for the HC-SR04 measurement controller: state encoding,
// 50 MHz timing defaults and the reduced simulation-scale timing.
package controle_medida_hcsr04_pkg;

  typedef enum logic [3:0] {
    INICIAL       = 4'd0,
    PREPARACAO    = 4'd1,
    ENVIA_TRIGGER = 4'd2,
    ESPERA_ECHO   = 4'd3,
    MEDINDO       = 4'd4,
    AGUARDA_CM    = 4'd5,
    ARMAZENA      = 4'd6,
    FINAL_MEDIDA  = 4'd7,
    ERRO          = 4'd8
  } estado_t;

  // 10 us trigger and 30 ms echo window at 50 MHz
  localparam int DEF_T_TRIG    = 500;
  localparam int DEF_T_TIMEOUT = 1500000;
  localparam int DEF_NT        = 21;

  localparam int SIM_T_TRIG    = 5;
  localparam int SIM_T_TIMEOUT = 100;
  localparam int SIM_NT        = 7;

  // Number of consecutive cycles a new echo level must hold to pass the filter
  localparam int FILT_CICLOS   = 3;

  function automatic int largura_timer(input int t_max);
    return $clog2(t_max + 1);
  endfunction

endpackage

// File: rtl/controle_medida_hcsr04_if.sv
// Signal bundle between the measurement controller and its surroundings
// (host request, sensor, cm-counting stage).
interface controle_medida_hcsr04_if;
  logic        medir;
  logic        echo;
  logic        pronto_cm;
  logic [3:0]  digito0;
  logic [3:0]  digito1;
  logic [3:0]  digito2;
  logic        trigger;
  logic        pulso;
  logic        zera_cm;
  logic [11:0] medida;
  logic        pronto;
  logic        timeout;
  logic [3:0]  db_estado;

  modport master (
    input  medir, echo, pronto_cm, digito0, digito1, digito2,
    output trigger, pulso, zera_cm, medida, pronto, timeout, db_estado
  );

  modport slave (
    output medir, echo, pronto_cm, digito0, digito1, digito2,
    input  trigger, pulso, zera_cm, medida, pronto, timeout, db_estado
  );
endinterface

// File: rtl/controle_medida_hcsr04_sincronizador_echo.sv
// Two-flop synchronizer for the raw echo; with ECHO_FILTER_EN defined a
// glitch filter follows it and only passes levels held for FILT_CICLOS cycles.
module sincronizador_echo
  import controle_medida_hcsr04_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic echo,
  output logic echo_s
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= echo;
      sync_p1 <= sync_p0;
    end
  end

`ifdef ECHO_FILTER_EN
  logic       echo_f;
  logic [1:0] estavel;

  // estavel counts how long sync_p1 has disagreed with the filtered level
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      echo_f  <= 1'b0;
      estavel <= '0;
    end else if (sync_p1 == echo_f) begin
      estavel <= '0;
    end else if (estavel == 2'(FILT_CICLOS - 1)) begin
      echo_f  <= sync_p1;
      estavel <= '0;
    end else begin
      estavel <= estavel + 2'd1;
    end
  end

  assign echo_s = echo_f;
`else
  assign echo_s = sync_p1;
`endif

endmodule

// File: rtl/controle_medida_hcsr04.sv
// HC-SR04 measurement controller: trigger, echo window supervision and BCD
// result latch. Optional echo glitch filter: define ECHO_FILTER_EN.
module controle_medida_hcsr04
  import controle_medida_hcsr04_pkg::*;
#(
  parameter int T_TRIG    = DEF_T_TRIG,
  parameter int T_TIMEOUT = DEF_T_TIMEOUT,
  parameter int NT        = DEF_NT
) (
  input  logic                     clock,
  input  logic                     reset_n,
  controle_medida_hcsr04_if.master bus
);

  localparam logic [NT-1:0] TRIG_FIM    = NT'(T_TRIG - 1);
  localparam logic [NT-1:0] TIMEOUT_FIM = NT'(T_TIMEOUT - 1);

  estado_t        estado;
  logic [NT-1:0]  timer;
  logic           echo_s;
  logic           trigger;
  logic           zera_cm;
  logic           pronto;
  logic           timeout;
  logic [11:0]    medida;

  sincronizador_echo u_sincronizador_echo (
    .clock   (clock),
    .reset_n (reset_n),
    .echo    (bus.echo),
    .echo_s  (echo_s)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado  <= INICIAL;
      timer   <= '0;
      trigger <= 1'b0;
      zera_cm <= 1'b0;
      pronto  <= 1'b0;
      timeout <= 1'b0;
      medida  <= '0;
    end else begin
      zera_cm <= 1'b0;
      pronto  <= 1'b0;
      case (estado)
        INICIAL: begin
          if (bus.medir) begin
            estado  <= PREPARACAO;
            zera_cm <= 1'b1;
            timeout <= 1'b0;
          end
        end
        PREPARACAO: begin
          estado  <= ENVIA_TRIGGER;
          trigger <= 1'b1;
          timer   <= '0;
        end
        ENVIA_TRIGGER: begin
          if (timer == TRIG_FIM) begin
            estado  <= ESPERA_ECHO;
            trigger <= 1'b0;
            timer   <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        // The echo edge is tested first so it wins over a coincident expiry
        ESPERA_ECHO: begin
          if (echo_s) begin
            estado <= MEDINDO;
            timer  <= '0;
          end else if (timer == TIMEOUT_FIM) begin
            estado  <= ERRO;
            timeout <= 1'b1;
            timer   <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        MEDINDO: begin
          if (!echo_s) begin
            estado <= AGUARDA_CM;
            timer  <= '0;
          end else if (timer == TIMEOUT_FIM) begin
            estado  <= ERRO;
            timeout <= 1'b1;
            timer   <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        AGUARDA_CM: begin
          if (bus.pronto_cm) estado <= ARMAZENA;
        end
        ARMAZENA: begin
          medida <= {bus.digito2, bus.digito1, bus.digito0};
          pronto <= 1'b1;
          estado <= FINAL_MEDIDA;
        end
        FINAL_MEDIDA: estado <= INICIAL;
        ERRO:         estado <= INICIAL;
        default: begin
          estado  <= INICIAL;
          timer   <= '0;
          trigger <= 1'b0;
        end
      endcase
    end
  end

  // A high echo_s in espera_echo always moves to medindo, so passing it one
  // cycle early keeps pulso exactly as wide as the synchronized echo.
  assign bus.pulso     = echo_s & ((estado == MEDINDO) | (estado == ESPERA_ECHO));
  assign bus.trigger   = trigger;
  assign bus.zera_cm   = zera_cm;
  assign bus.pronto    = pronto;
  assign bus.timeout   = timeout;
  assign bus.medida    = medida;
  assign bus.db_estado = estado;

endmodule

// File: tb/tb_controle_medida_hcsr04.sv
// Directed bench for controle_medida_hcsr04 at simulation timing (T_TRIG=5, T_TIMEOUT=100).
module tb_controle_medida_hcsr04;
  import controle_medida_hcsr04_pkg::*;

`ifdef ECHO_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 2;
`endif

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;
  int   stepn, trig_cnt, pulso_cnt, pronto_cnt, first_pulso, last_pulso;
  logic saw_medindo;
  int   n;

  controle_medida_hcsr04_if bus ();

  controle_medida_hcsr04 #(
    .T_TRIG    (SIM_T_TRIG),
    .T_TIMEOUT (SIM_T_TIMEOUT),
    .NT        (SIM_NT)
  ) dut (
    .clock   (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    stepn = 0; trig_cnt = 0; pulso_cnt = 0; pronto_cnt = 0;
    first_pulso = 0; last_pulso = 0; saw_medindo = 1'b0;
  endtask

  task automatic step(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      @(negedge clk);
      stepn++;
      if (bus.trigger) trig_cnt++;
      if (bus.pulso) begin
        pulso_cnt++;
        if (first_pulso == 0) first_pulso = stepn;
        last_pulso = stepn;
      end
      if (bus.pronto) pronto_cnt++;
      if (bus.db_estado == 4'd4) saw_medindo = 1'b1;
    end
  endtask

  task automatic wait_state(input string tag, input logic [3:0] tgt, input int budget, output int steps);
    steps = 0;
    while (bus.db_estado !== tgt && steps < budget) begin
      step(1);
      steps++;
    end
    chk(tag, 32'(bus.db_estado), 32'(tgt));
  endtask

  task automatic set_digits(input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0);
    bus.digito2 = d2; bus.digito1 = d1; bus.digito0 = d0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0; miscompares = 0; clr();
    reset_n = 1'b0;
    bus.medir = 1'b0; bus.echo = 1'b0; bus.pronto_cm = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0);

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_trigger", 32'(bus.trigger), 32'd0);
    chk("rst_pulso", 32'(bus.pulso), 32'd0);
    chk("rst_zera_cm", 32'(bus.zera_cm), 32'd0);
    chk("rst_medida", 32'(bus.medida), 32'h000);
    chk("rst_pronto_timeout", 32'({bus.pronto, bus.timeout}), 32'd0);
    chk("rst_estado", 32'(bus.db_estado), 32'(INICIAL));
    reset_n = 1'b1;

    // normal measurement
    bus.medir = 1'b1;
    step(1);
    bus.medir = 1'b0;
    chk("t1_prep_estado", 32'(bus.db_estado), 32'(PREPARACAO));
    chk("t1_prep_zera", 32'(bus.zera_cm), 32'd1);
    clr();
    wait_state("t1_reach_espera", ESPERA_ECHO, 20, n);
    chk("t1_trigger_width", 32'(trig_cnt), 32'd5);
    step(40);
    clr();
    bus.echo = 1'b1;
    step(60);
    bus.echo = 1'b0;
    step(3);
    bus.pronto_cm = 1'b1;
    set_digits(4'd3, 4'd2, 4'd1);
    wait_state("t1_reach_final", FINAL_MEDIDA, 20, n);
    chk("t1_pulso_width", 32'(pulso_cnt), 32'd60);
    chk("t1_pulso_rise", 32'(first_pulso), 32'(LAT));
    chk("t1_pulso_fall", 32'(last_pulso), 32'(59 + LAT));
    chk("t1_medida", 32'(bus.medida), 32'h321);
    chk("t1_pronto", 32'(bus.pronto), 32'd1);
    chk("t1_timeout", 32'(bus.timeout), 32'd0);
    bus.pronto_cm = 1'b0;
    step(1);
    chk("t1_pronto_single", 32'({bus.pronto, bus.db_estado}), 32'(INICIAL));

    // no echo: timeout from espera_echo
    bus.medir = 1'b1;
    step(1);
    bus.medir = 1'b0;
    wait_state("t2_reach_espera", ESPERA_ECHO, 20, n);
    clr();
    wait_state("t2_reach_erro", ERRO, 200, n);
    chk("t2_erro_latency", 32'(n), 32'd100);
    chk("t2_timeout", 32'(bus.timeout), 32'd1);
    chk("t2_medida_held", 32'(bus.medida), 32'h321);
    chk("t2_no_pronto", 32'(pronto_cnt), 32'd0);
    step(1);
    chk("t2_back_inicial", 32'({bus.timeout, bus.db_estado}), 32'h10);

    // echo stuck high: timeout from medindo
    bus.medir = 1'b1;
    step(1);
    bus.medir = 1'b0;
    wait_state("t3_reach_espera", ESPERA_ECHO, 20, n);
    bus.echo = 1'b1;
    wait_state("t3_reach_medindo", MEDINDO, 20, n);
    wait_state("t3_reach_erro", ERRO, 200, n);
    chk("t3_medindo_latency", 32'(n), 32'd100);
    chk("t3_pulso_drop", 32'(bus.pulso), 32'd0);
    chk("t3_timeout", 32'(bus.timeout), 32'd1);
    step(40);
    bus.echo = 1'b0;
    step(8);

    // asynchronous reset during medindo
    bus.medir = 1'b1;
    step(1);
    bus.medir = 1'b0;
    wait_state("t4_reach_espera", ESPERA_ECHO, 20, n);
    bus.echo = 1'b1;
    wait_state("t4_reach_medindo", MEDINDO, 20, n);
    step(3);
    chk("t4_pulso_before", 32'(bus.pulso), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t4_async_trigger_pulso", 32'({bus.trigger, bus.pulso}), 32'd0);
    chk("t4_async_medida", 32'(bus.medida), 32'h000);
    chk("t4_async_estado", 32'(bus.db_estado), 32'(INICIAL));
    bus.echo = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step(2);

    // asynchronous reset while the trigger is high
    bus.medir = 1'b1;
    step(1);
    bus.medir = 1'b0;
    step(2);
    chk("t4b_trigger_high", 32'(bus.trigger), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t4b_async_trigger", 32'({bus.trigger, bus.db_estado}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step(2);

    // two-cycle echo glitch during espera_echo
    bus.medir = 1'b1;
    step(1);
    bus.medir = 1'b0;
    wait_state("t5_reach_espera", ESPERA_ECHO, 20, n);
    step(10);
    clr();
    bus.echo = 1'b1;
    step(2);
    bus.echo = 1'b0;
    step(6);
`ifdef ECHO_FILTER_EN
    chk("t5_glitch_pulso", 32'(pulso_cnt), 32'd0);
    wait_state("t5_reach_erro", ERRO, 200, n);
    chk("t5_glitch_no_medindo", 32'(saw_medindo), 32'd0);
    chk("t5_timeout", 32'(bus.timeout), 32'd1);
    step(1);
`else
    chk("t5_glitch_pulso", 32'(pulso_cnt), 32'd2);
    chk("t5_glitch_medindo", 32'(saw_medindo), 32'd1);
    chk("t5_glitch_aguarda", 32'(bus.db_estado), 32'(AGUARDA_CM));
    bus.pronto_cm = 1'b1;
    set_digits(4'd6, 4'd5, 4'd4);
    wait_state("t5_reach_final", FINAL_MEDIDA, 10, n);
    chk("t5_medida", 32'(bus.medida), 32'h654);
    bus.pronto_cm = 1'b0;
    step(1);
`endif

    // back-to-back with medir held: timeout run, then a 20-cycle echo
    bus.medir = 1'b1;
    step(1);
    chk("t6_first_prep", 32'(bus.db_estado), 32'(PREPARACAO));
    wait_state("t6_reach_erro", ERRO, 300, n);
    chk("t6_first_timeout", 32'(bus.timeout), 32'd1);
    wait_state("t6_reach_prep2", PREPARACAO, 10, n);
    chk("t6_prep2_zera_timeout", 32'({bus.zera_cm, bus.timeout}), 32'b10);
    wait_state("t6_reach_espera2", ESPERA_ECHO, 20, n);
    step(5);
    clr();
    bus.echo = 1'b1;
    step(20);
    bus.echo = 1'b0;
    wait_state("t6_reach_aguarda", AGUARDA_CM, 20, n);
    bus.medir = 1'b0;
    chk("t6_pulso_width", 32'(pulso_cnt), 32'd20);
    bus.pronto_cm = 1'b1;
    set_digits(4'd9, 4'd8, 4'd7);
    wait_state("t6_reach_final", FINAL_MEDIDA, 10, n);
    chk("t6_pronto", 32'(bus.pronto), 32'd1);
    chk("t6_medida", 32'(bus.medida), 32'h987);
    chk("t6_timeout_clear", 32'(bus.timeout), 32'd0);
    bus.pronto_cm = 1'b0;
    step(1);
    chk("t6_idle", 32'({bus.pronto, bus.db_estado}), 32'(INICIAL));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
